// File: rtl/gray_to_rgb_colorizer.sv
// Two-stage valid/ready colorizer: expands 8-bit gray into RGB using one of four
// runtime-selectable mappings, with full backpressure and an output transfer counter.
module gray_to_rgb_colorizer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       GrayIn,
  input  logic             InValid,
  output logic             InReady,
  input  logic             CfgWe,
  input  logic [1:0]       CfgMode,
  input  logic [23:0]      CfgTint,
  output logic [7:0]       RedOut,
  output logic [7:0]       GreenOut,
  output logic [7:0]       BlueOut,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [CNT_W-1:0] PixelCount
);

  typedef enum logic [1:0] {
    MODE_REPLICATE = 2'd0,
    MODE_TINT      = 2'd1,
    MODE_HEATMAP   = 2'd2,
    MODE_INVERT    = 2'd3
  } mode_e;

  mode_e             r_mode;
  logic [23:0]       r_tint;

  logic              r_s1_valid;
  logic [7:0]        r_s1_gray;
  mode_e             r_s1_mode;
  logic [23:0]       r_s1_tint;

  logic              r_out_valid;
  logic [7:0]        r_red;
  logic [7:0]        r_green;
  logic [7:0]        r_blue;
  logic [CNT_W-1:0]  r_count;

  logic              w_s2_en;
  logic              w_s1_en;
  logic [7:0]        w_red;
  logic [7:0]        w_green;
  logic [7:0]        w_blue;
  logic [7:0]        w_ramp;

  // (g*t + g) >> 8 never exceeds 16 bits and maps tint 255 exactly onto g.
  function automatic logic [7:0] tint_channel(input logic [7:0] g, input logic [7:0] t);
    logic [15:0] p;
    p = 16'(g) * 16'(t) + 16'(g);
    return p[15:8];
  endfunction

  assign w_s2_en = ~r_out_valid | OutReady;
  assign w_s1_en = ~r_s1_valid | w_s2_en;
  assign InReady = w_s1_en;

  // Heatmap ramp: 2g in the lower half, 2(g-128) in the upper half.
  assign w_ramp = {r_s1_gray[6:0], 1'b0};

  always_comb begin
    w_red   = '0;
    w_green = '0;
    w_blue  = '0;
    unique case (r_s1_mode)
      MODE_REPLICATE: begin
        w_red   = r_s1_gray;
        w_green = r_s1_gray;
        w_blue  = r_s1_gray;
      end
      MODE_TINT: begin
        w_red   = tint_channel(r_s1_gray, r_s1_tint[23:16]);
        w_green = tint_channel(r_s1_gray, r_s1_tint[15:8]);
        w_blue  = tint_channel(r_s1_gray, r_s1_tint[7:0]);
      end
      MODE_HEATMAP: begin
        if (!r_s1_gray[7]) begin
          w_green = w_ramp;
          w_blue  = 8'd255 - w_ramp;
        end else begin
          w_red   = w_ramp;
          w_green = 8'd255 - w_ramp;
        end
      end
      MODE_INVERT: begin
        w_red   = ~r_s1_gray;
        w_green = ~r_s1_gray;
        w_blue  = ~r_s1_gray;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode      <= MODE_REPLICATE;
      r_tint      <= '1;
      r_s1_valid  <= 1'b0;
      r_s1_gray   <= '0;
      r_s1_mode   <= MODE_REPLICATE;
      r_s1_tint   <= '1;
      r_out_valid <= 1'b0;
      r_red       <= '0;
      r_green     <= '0;
      r_blue      <= '0;
      r_count     <= '0;
    end else begin
      if (CfgWe) begin
        r_mode <= mode_e'(CfgMode);
        r_tint <= CfgTint;
      end
      // Stage 1 snapshots the pre-write config, so a same-cycle CfgWe affects only later pixels.
      if (w_s1_en) begin
        r_s1_valid <= InValid;
        if (InValid) begin
          r_s1_gray <= GrayIn;
          r_s1_mode <= r_mode;
          r_s1_tint <= r_tint;
        end
      end
      if (w_s2_en) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_red   <= w_red;
          r_green <= w_green;
          r_blue  <= w_blue;
        end
      end
      if (r_out_valid && OutReady) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign OutValid   = r_out_valid;
  assign RedOut     = r_red;
  assign GreenOut   = r_green;
  assign BlueOut    = r_blue;
  assign PixelCount = r_count;

endmodule
